pixel_bin_packer: RTL and testbench
===================================

PIXEL_BIN_PACKER -- requirements
Module: pixel_bin_packer

Interface
REQ-001 SHALL have parameter PIX_W, default 12, input pixel width in bits.
REQ-002 SHALL have parameter PACK_N, default 8, pixels per packed word; legal range 1..OUT_W.
REQ-003 SHALL have parameter OUT_W, default 16, output word width; bits [OUT_W-1:PACK_N] always 0.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, output FIFO entries; power of 2, minimum 2.
REQ-005 SHALL have port iCLK, input, 1 bit: single clock for all logic.
REQ-006 SHALL have port iRST, input, 1 bit: reset, synchronous, active-high.
REQ-007 SHALL have port iDATA, input, PIX_W bits: pixel value.
REQ-008 SHALL have port iDVAL, input, 1 bit: iDATA valid this cycle; no backpressure toward the pixel source.
REQ-009 SHALL have port iEOL, input, 1 bit: end-of-line pulse; when iDVAL=1 it marks that pixel as the last of the line.
REQ-010 SHALL have port iFVAL, input, 1 bit: frame valid level.
REQ-011 SHALL have port iTHRESH, input, PIX_W bits: binarisation threshold.
REQ-012 SHALL have port iINVERT, input, 1 bit: invert binarised bit.
REQ-013 SHALL have port oDATA, output, OUT_W bits: FIFO head word.
REQ-014 SHALL have port oLAST, output, 1 bit: head word holds the last pixel of a line.
REQ-015 SHALL have port oVALID, output, 1 bit: FIFO non-empty.
REQ-016 SHALL have port iREADY, input, 1 bit: consumer accepts the head word when oVALID and iREADY are both 1.
REQ-017 SHALL have port oOVERFLOW, output, 1 bit: sticky word-dropped flag.
REQ-018 SHALL have port oLEVEL, output, clog2(FIFO_DEPTH)+1 bits: FIFO occupancy.
REQ-019 SHALL have port oWORD_CNT, output, 32 bits: number of words written to the FIFO in the current frame.

Function
REQ-020 Bit b = (iDATA >= iTHRESH) XOR iINVERT, evaluated in the cycle iDVAL=1; comparison unsigned.
REQ-021 Accumulator: bit of the k-th pixel of a group (k=0..PACK_N-1) lands at word bit k, so the first pixel goes to the LSB; 0..PACK_N-1 fill counter.
REQ-022 On the edge sampling the PACK_N-th pixel, the completed word is written to the FIFO and the fill counter returns to 0; oVALID goes high after that same edge if the FIFO was empty (latency 1 edge).
REQ-023 iDVAL=1 and iEOL=1: the word including that pixel is written immediately, padded with 0s above the fill position, with oLAST=1, even if partial.
REQ-024 iEOL=1 and iDVAL=0: if fill>0, flush the partial word with oLAST=1; if fill=0, do nothing.
REQ-025 A word completing at PACK_N on an iEOL pixel is written once, with oLAST=1; no extra empty word.
REQ-026 iFVAL rising edge (registered prior value 0, current 1): clears the fill counter and accumulator without writing a word, and sets oWORD_CNT to 0; a pixel with iDVAL=1 in the same cycle becomes group bit 0.
REQ-027 FIFO is first-word-fall-through: oDATA/oLAST show the head while oVALID=1; a pop occurs on an edge with oVALID and iREADY both 1.
REQ-028 Write when full: accepted only if a pop occurs on the same edge; otherwise the word is dropped, oOVERFLOW is set, and oWORD_CNT does not increment.
REQ-029 Simultaneous push and pop: oLEVEL is unchanged; an empty FIFO never pops.
REQ-030 oWORD_CNT increments by 1 per accepted FIFO write and wraps modulo 2^32.
REQ-031 iDVAL=0 and iEOL=0: no state change except FIFO pops.

Reset
REQ-032 iRST=1 at an edge: fill counter, accumulator, and FIFO pointers go to 0; oVALID=0, oLEVEL=0, oOVERFLOW=0, oWORD_CNT=0, registered iFVAL=0.
REQ-033 After reset: oDATA=0 and oLAST=0 while oVALID=0.
REQ-034 Reset mid-group or with the FIFO non-empty: all pending data is discarded and no word is emitted.
REQ-035 oOVERFLOW is cleared only by iRST.

Verification
REQ-036 Defaults, iTHRESH=0x800, iREADY=1, 8 pixels 0xFFF,0,0xFFF,0,0,0,0,0xFFF -> one word 0x0085 with oLAST=0, one edge after the 8th pixel.
REQ-037 Same pixels with iINVERT=1 -> 0x007A.
REQ-038 Line of 11 pixels all >= iTHRESH, iEOL on the 11th -> 0x00FF with oLAST=0, then 0x0007 with oLAST=1; oWORD_CNT=2.
REQ-039 iREADY=0, 5 full words pushed (FIFO_DEPTH=4) -> oLEVEL=4, oOVERFLOW=1, oWORD_CNT=4; draining returns the first 4 words in order.
REQ-040 3 pixels, then iFVAL 0->1, then 8 pixels -> exactly one word, built from the last 8 pixels; oWORD_CNT=1.
REQ-041 iRST asserted while fill=5 and oLEVEL=2 -> next edge: oVALID=0, oLEVEL=0; the next 8 pixels form a fresh word.

Source files
------------

// File: rtl/pixel_bin_packer.sv
// Binarises a pixel stream against a threshold, packs PACK_N bits per word
// (first pixel in the LSB) and queues the words in a first-word-fall-through FIFO.
module pixel_bin_packer #(
   parameter int PIX_W      = 12,
   parameter int PACK_N     = 8,
   parameter int OUT_W      = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          iCLK,
   input  logic                          iRST,
   input  logic [PIX_W-1:0]              iDATA,
   input  logic                          iDVAL,
   input  logic                          iEOL,
   input  logic                          iFVAL,
   input  logic [PIX_W-1:0]              iTHRESH,
   input  logic                          iINVERT,
   output logic [OUT_W-1:0]              oDATA,
   output logic                          oLAST,
   output logic                          oVALID,
   input  logic                          iREADY,
   output logic                          oOVERFLOW,
   output logic [$clog2(FIFO_DEPTH):0]   oLEVEL,
   output logic [31:0]                   oWORD_CNT
);

   localparam int FILL_W = (PACK_N > 1) ? $clog2(PACK_N) : 1;
   localparam int AW     = $clog2(FIFO_DEPTH);
   localparam int LVL_W  = AW + 1;

   typedef struct packed {
      logic              last;
      logic [PACK_N-1:0] data;
   } entry_t;

   logic              fval_q;
   logic [FILL_W-1:0] fill_q, fill_d;
   logic [PACK_N-1:0] acc_q, acc_d;
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]  level_q, level_d;
   logic              ovf_q, ovf_d;
   logic [31:0]       cnt_q, cnt_d;
   entry_t            mem_q [FIFO_DEPTH];

   logic              fval_rise;
   logic [FILL_W-1:0] base_fill;
   logic [PACK_N-1:0] base_acc;
   logic              pix_bit;
   logic              push, push_ok, pop, full;
   entry_t            push_entry, head;

   assign fval_rise = iFVAL & ~fval_q;
   assign base_fill = fval_rise ? '0 : fill_q;
   assign base_acc  = fval_rise ? '0 : acc_q;
   assign pix_bit   = (iDATA >= iTHRESH) ^ iINVERT;

   // A frame start discards the partial group; the same-cycle pixel becomes bit 0.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      fill_d     = base_fill;
      acc_d      = base_acc;
      push       = 1'b0;
      push_entry = '0;
      if (iDVAL) begin
         push_entry.data            = base_acc;
         push_entry.data[base_fill] = pix_bit;
         push_entry.last            = iEOL;
         if (iEOL || (base_fill == FILL_W'(PACK_N - 1))) begin
            push   = 1'b1;
            fill_d = '0;
            acc_d  = '0;
         end else begin
            fill_d = base_fill + FILL_W'(1);
            acc_d  = push_entry.data;
         end
      end else if (iEOL && (base_fill != '0)) begin
         push            = 1'b1;
         push_entry.data = base_acc;
         push_entry.last = 1'b1;
         fill_d          = '0;
         acc_d           = '0;
      end
   end

   assign full    = (level_q == LVL_W'(FIFO_DEPTH));
   assign pop     = (level_q != '0) && iREADY;
   assign push_ok = push && (!full || pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q + AW'(push_ok);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      level_d  = level_q + LVL_W'(push_ok) - LVL_W'(pop);
      ovf_d    = ovf_q | (push && full && !pop);
      cnt_d    = (fval_rise ? 32'd0 : cnt_q) + 32'(push_ok);
   end

   // NOTE: non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         fval_q   <= 1'b0;
         fill_q   <= '0;
         acc_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         ovf_q    <= 1'b0;
         cnt_q    <= '0;
      end else begin
         fval_q   <= iFVAL;
         fill_q   <= fill_d;
         acc_q    <= acc_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         ovf_q    <= ovf_d;
         cnt_q    <= cnt_d;
      end
   end

   // NOTE: storage is not reset; the level counter alone decides which entries are live.
   always_ff @(posedge iCLK) begin
      if (!iRST && push_ok) mem_q[wr_ptr_q] <= push_entry;
   end

   assign head = mem_q[rd_ptr_q];

   always_comb begin
      oDATA = '0;
      oLAST = 1'b0;
      if (oVALID) begin
         oDATA[PACK_N-1:0] = head.data;
         oLAST             = head.last;
      end
   end

   assign oVALID    = (level_q != '0);
   assign oLEVEL    = level_q;
   assign oOVERFLOW = ovf_q;
   assign oWORD_CNT = cnt_q;

endmodule

// File: tb/tb_pixel_bin_packer.sv
// Self-checking bench for pixel_bin_packer: directed scenarios plus a randomised
// run compared against a queue-based reference model.
module tb_pixel_bin_packer;

   localparam int PACK_N = 8;
   localparam int DEPTH  = 4;

   logic        iCLK = 1'b0;
   logic        iRST, iDVAL, iEOL, iFVAL, iINVERT, iREADY;
   logic [11:0] iDATA, iTHRESH;
   logic [15:0] oDATA;
   logic        oLAST, oVALID, oOVERFLOW;
   logic [2:0]  oLEVEL;
   logic [31:0] oWORD_CNT;

   int n_checks = 0;
   int n_fail   = 0;

   pixel_bin_packer dut (
      .iCLK(iCLK), .iRST(iRST), .iDATA(iDATA), .iDVAL(iDVAL), .iEOL(iEOL),
      .iFVAL(iFVAL), .iTHRESH(iTHRESH), .iINVERT(iINVERT), .oDATA(oDATA),
      .oLAST(oLAST), .oVALID(oVALID), .iREADY(iREADY), .oOVERFLOW(oOVERFLOW),
      .oLEVEL(oLEVEL), .oWORD_CNT(oWORD_CNT)
   );

   always #5 iCLK = ~iCLK;

   // Reference model: pending pixel bits, queued words, flags.
   typedef struct {
      bit          last;
      logic [15:0] data;
   } ent_t;

   bit          grp[$];
   ent_t        fifo[$];
   bit          m_ovf;
   logic [31:0] m_cnt;
   bit          m_fval_prev;

   function automatic logic [15:0] pack_grp();
      logic [15:0] w = 16'd0;
      foreach (grp[k]) if (grp[k]) w = w | (16'd1 << k);
      return w;
   endfunction

   function automatic logic [15:0] exp_data();
      return (fifo.size() > 0) ? fifo[0].data : 16'd0;
   endfunction

   function automatic bit exp_last();
      return (fifo.size() > 0) ? fifo[0].last : 1'b0;
   endfunction

   task automatic model_reset();
      grp.delete();
      fifo.delete();
      m_ovf       = 1'b0;
      m_cnt       = 32'd0;
      m_fval_prev = 1'b0;
   endtask

   task automatic model_edge();
      bit   do_pop, do_push, was_full;
      ent_t e;
      do_pop   = (fifo.size() > 0) && iREADY;
      was_full = (fifo.size() == DEPTH);
      do_push  = 1'b0;
      if (iFVAL && !m_fval_prev) begin
         grp.delete();
         m_cnt = 32'd0;
      end
      if (iDVAL) begin
         grp.push_back((iDATA >= iTHRESH) ^ iINVERT);
         if (grp.size() == PACK_N || iEOL) begin
            e.data = pack_grp(); e.last = iEOL; do_push = 1'b1;
            grp.delete();
         end
      end else if (iEOL && grp.size() > 0) begin
         e.data = pack_grp(); e.last = 1'b1; do_push = 1'b1;
         grp.delete();
      end
      if (do_pop) void'(fifo.pop_front());
      if (do_push) begin
         if (!was_full || do_pop) begin
            fifo.push_back(e);
            m_cnt = m_cnt + 32'd1;
         end else begin
            m_ovf = 1'b1;
         end
      end
      m_fval_prev = iFVAL;
   endtask

   task automatic step(input bit dv, input logic [11:0] d, input bit eol,
                       input bit fv, input bit rdy);
      iDVAL = dv; iDATA = d; iEOL = eol; iFVAL = fv; iREADY = rdy;
      @(posedge iCLK);
      model_edge();
      #1;
   endtask

   task automatic do_reset();
      iRST = 1'b1; iDVAL = 1'b0; iEOL = 1'b0; iFVAL = 1'b0; iREADY = 1'b0;
      iDATA = '0;
      @(posedge iCLK);
      model_reset();
      #1;
      iRST = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if ({oVALID, oLAST, oOVERFLOW} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_flags: got valid/last/ovf=%b%b%b want 000", oVALID, oLAST, oOVERFLOW);
      end
      n_checks++;
      if (oDATA !== 16'd0 || oLEVEL !== 3'd0 || oWORD_CNT !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_values: got data=%h level=%0d cnt=%0d want 0/0/0", oDATA, oLEVEL, oWORD_CNT);
      end
   endtask

   task automatic test_word(input bit inv, input logic [15:0] want);
      logic [11:0] px [8] = '{12'hFFF, 12'h0, 12'hFFF, 12'h0, 12'h0, 12'h0, 12'h0, 12'hFFF};
      do_reset();
      iTHRESH = 12'h800; iINVERT = inv;
      step(0, 0, 0, 1, 1);
      foreach (px[i]) begin
         step(1, px[i], 0, 1, 1);
         if (i < 7) begin
            n_checks++;
            if (oVALID !== 1'b0) begin
               n_fail++;
               $display("FAIL word_early inv=%0d px=%0d: got valid=%b want 0", inv, i, oVALID);
            end
         end
      end
      n_checks++;
      if (oVALID !== 1'b1 || oDATA !== want || oLAST !== 1'b0) begin
         n_fail++;
         $display("FAIL word inv=%0d: got valid=%b data=%h last=%b want 1 %h 0", inv, oVALID, oDATA, oLAST, want);
      end
   endtask

   task automatic test_eol_line();
      do_reset();
      iTHRESH = 12'h800; iINVERT = 1'b0;
      step(0, 0, 0, 1, 0);
      for (int i = 0; i < 11; i++) step(1, 12'h900 + 12'(i), (i == 10), 1, 0);
      n_checks++;
      if (oLEVEL !== 3'd2 || oWORD_CNT !== 32'd2 || oDATA !== 16'h00FF || oLAST !== 1'b0) begin
         n_fail++;
         $display("FAIL eol_first: got level=%0d cnt=%0d data=%h last=%b want 2 2 00ff 0", oLEVEL, oWORD_CNT, oDATA, oLAST);
      end
      step(0, 0, 0, 1, 1);
      n_checks++;
      if (oVALID !== 1'b1 || oDATA !== 16'h0007 || oLAST !== 1'b1) begin
         n_fail++;
         $display("FAIL eol_second: got valid=%b data=%h last=%b want 1 0007 1", oVALID, oDATA, oLAST);
      end
      step(0, 0, 1, 1, 1);
      n_checks++;
      if (oVALID !== 1'b0 || oLEVEL !== 3'd0) begin
         n_fail++;
         $display("FAIL eol_drain: got valid=%b level=%0d want 0 0", oVALID, oLEVEL);
      end
   endtask

   task automatic test_overflow();
      do_reset();
      iTHRESH = 12'h800; iINVERT = 1'b0;
      step(0, 0, 0, 1, 0);
      for (int i = 0; i < 5 * PACK_N; i++) step(1, 12'($urandom), 0, 1, 0);
      n_checks++;
      if (oLEVEL !== 3'd4 || oOVERFLOW !== 1'b1 || oWORD_CNT !== 32'd4) begin
         n_fail++;
         $display("FAIL overflow_state: got level=%0d ovf=%b cnt=%0d want 4 1 4", oLEVEL, oOVERFLOW, oWORD_CNT);
      end
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (oVALID !== 1'b1 || oDATA !== exp_data() || oLAST !== exp_last()) begin
            n_fail++;
            $display("FAIL overflow_drain[%0d]: got valid=%b data=%h last=%b want 1 %h %b",
                     i, oVALID, oDATA, oLAST, exp_data(), exp_last());
         end
         step(0, 0, 0, 1, 1);
      end
      n_checks++;
      if (oVALID !== 1'b0 || oOVERFLOW !== 1'b1) begin
         n_fail++;
         $display("FAIL overflow_sticky: got valid=%b ovf=%b want 0 1", oVALID, oOVERFLOW);
      end
   endtask

   task automatic test_fval_restart();
      logic [11:0] px;
      logic [15:0] want = 16'd0;
      do_reset();
      iTHRESH = 12'($urandom); iINVERT = 1'($urandom);
      step(0, 0, 0, 1, 0);
      for (int i = 0; i < 3; i++) step(1, 12'($urandom), 0, 1, 0);
      step(0, 0, 0, 0, 0);
      for (int i = 0; i < 8; i++) begin
         px = 12'($urandom);
         if ((px >= iTHRESH) ^ iINVERT) want[i] = 1'b1;
         step(1, px, 0, 1, 0);
      end
      n_checks++;
      if (oLEVEL !== 3'd1 || oWORD_CNT !== 32'd1 || oDATA !== want) begin
         n_fail++;
         $display("FAIL fval_restart: got level=%0d cnt=%0d data=%h want 1 1 %h", oLEVEL, oWORD_CNT, oDATA, want);
      end
   endtask

   task automatic test_reset_mid();
      logic [11:0] px;
      logic [15:0] want = 16'd0;
      do_reset();
      iTHRESH = 12'h400; iINVERT = 1'b0;
      step(0, 0, 0, 1, 0);
      for (int i = 0; i < 2 * PACK_N + 5; i++) step(1, 12'($urandom), 0, 1, 0);
      n_checks++;
      if (oLEVEL !== 3'd2) begin
         n_fail++;
         $display("FAIL reset_mid_pre: got level=%0d want 2", oLEVEL);
      end
      do_reset();
      n_checks++;
      if (oVALID !== 1'b0 || oLEVEL !== 3'd0) begin
         n_fail++;
         $display("FAIL reset_mid_post: got valid=%b level=%0d want 0 0", oVALID, oLEVEL);
      end
      for (int i = 0; i < 8; i++) begin
         px = 12'($urandom);
         if (px >= iTHRESH) want[i] = 1'b1;
         step(1, px, 0, 1, 0);
      end
      n_checks++;
      if (oLEVEL !== 3'd1 || oDATA !== want || oLAST !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_fresh: got level=%0d data=%h last=%b want 1 %h 0", oLEVEL, oDATA, oLAST, want);
      end
   endtask

   task automatic test_random();
      bit fv = 1'b1;
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 49) == 0) fv = ~fv;
         if ($urandom_range(0, 99) == 0) iTHRESH = 12'($urandom);
         if ($urandom_range(0, 199) == 0) iINVERT = ~iINVERT;
         step($urandom_range(0, 9) < 7, 12'($urandom), $urandom_range(0, 9) == 0, fv,
              $urandom_range(0, 9) < 6);
         n_checks++;
         if (oVALID !== (fifo.size() > 0) || oDATA !== exp_data() || oLAST !== exp_last()) begin
            n_fail++;
            $display("FAIL random_head c=%0d: got valid=%b data=%h last=%b want %b %h %b",
                     c, oVALID, oDATA, oLAST, fifo.size() > 0, exp_data(), exp_last());
         end
         n_checks++;
         if (oLEVEL !== 3'(fifo.size()) || oOVERFLOW !== m_ovf || oWORD_CNT !== m_cnt) begin
            n_fail++;
            $display("FAIL random_stat c=%0d: got level=%0d ovf=%b cnt=%0d want %0d %b %0d",
                     c, oLEVEL, oOVERFLOW, oWORD_CNT, fifo.size(), m_ovf, m_cnt);
         end
      end
   endtask

   initial begin
      iTHRESH = 12'h800; iINVERT = 1'b0;
      test_reset();
      test_word(1'b0, 16'h0085);
      test_word(1'b1, 16'h007A);
      test_eol_line();
      test_overflow();
      test_fval_restart();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
